param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_next_val.sv | 66 ++++++
 rtl/param_updown_counter.sv | 65 ++++++
 tb/tb_param_updown_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
// Latency: n/a (types only).
// Backpressure: n/a.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-state for the up/down counter: load clamp, step, boundary flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; enable is the only throttle.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter count_mode_e     MODE      = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_val,
    output logic             next_wrap,
    output logic             next_sat
);

    localparam logic [WIDTH:0]   MAX_EXT = MAX_COUNT[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W   = MAX_COUNT[WIDTH-1:0];

    // One guard bit so the +1 overflow and the -1 borrow are both visible.
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] load_ext;

    assign inc_ext  = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext  = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};
    assign load_ext = {1'b0, load_val};

    always_comb begin
        next_val  = cur;
        next_wrap = 1'b0;
        next_sat  = 1'b0;
        if (load) begin
            next_val = (load_ext > MAX_EXT) ? MAX_W : load_val;
        end else if (enable) begin
            if (up_down) begin
                if (inc_ext > MAX_EXT) begin
                    if (MODE == MODE_WRAP) begin
                        next_val  = '0;
                        next_wrap = 1'b1;
                    end else begin
                        next_sat  = 1'b1;
                    end
                end else begin
                    next_val = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (dec_ext[WIDTH]) begin
                    if (MODE == MODE_WRAP) begin
                        next_val  = MAX_W;
                        next_wrap = 1'b1;
                    end else begin
                        next_sat  = 1'b1;
                    end
                end else begin
                    next_val = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with load, wrap or saturate at 0..MAX_COUNT.
// Latency: 1 cycle from enable/load to out; tc is combinational.
// Backpressure: none; enable=0 holds the count.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter count_mode_e     MODE      = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_COUNT[WIDTH-1:0];

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 2..32");
    end
    if (MAX_COUNT == 64'd0 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("param_updown_counter: MAX_COUNT must be 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] next_val;
    logic             next_wrap;
    logic             next_sat;

    counter_next_val #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .MODE      (MODE)
    ) u_next (
        .cur       (out),
        .enable    (enable),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .next_val  (next_val),
        .next_wrap (next_wrap),
        .next_sat  (next_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            out  <= next_val;
            wrap <= next_wrap;
            sat  <= next_sat;
        end
    end

    assign tc = up_down ? (out == MAX_W) : (out == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: WIDTH=4/MAX=9 in wrap and saturate modes, plus default parameters.
// All three instances share stimulus; each task checks the instance it targets.
module tb_param_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [3:0] out_w, out_s;
    logic [7:0] out_d;
    logic       tc_w, wrap_w, sat_w;
    logic       tc_s, wrap_s, sat_s;
    logic       tc_d, wrap_d, sat_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .MODE(MODE_WRAP)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .out(out_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w));

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .MODE(MODE_SAT)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .out(out_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s));

    param_updown_counter dut_d (
        .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
        .load_val(load_val), .out(out_d), .tc(tc_d), .wrap(wrap_d), .sat(sat_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1; load = 1'b1; load_val = 8'd5; up_down = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (out_w !== 4'd0 || wrap_w !== 1'b0 || sat_w !== 1'b0) begin
            errors++; $display("FAIL reset_w out=%0d wrap=%b sat=%b exp 0/0/0", out_w, wrap_w, sat_w);
        end
        checks++;
        if (out_s !== 4'd0 || sat_s !== 1'b0 || out_d !== 8'd0) begin
            errors++; $display("FAIL reset_s_d out_s=%0d sat_s=%b out_d=%0d exp 0/0/0", out_s, sat_s, out_d);
        end
        checks++;
        if (tc_w !== 1'b1) begin
            errors++; $display("FAIL reset_tc_down tc=%b exp 1", tc_w);
        end
        up_down = 1'b1;
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            errors++; $display("FAIL reset_tc_up tc=%b exp 0", tc_w);
        end
        rst = 1'b0; enable = 1'b0; load = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_out [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic       exp_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic       exp_tc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        enable = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (out_w !== exp_out[i] || wrap_w !== exp_wrap[i] || tc_w !== exp_tc[i]) begin
                errors++;
                $display("FAIL wrap_up[%0d] out=%0d wrap=%b tc=%b exp %0d/%b/%b",
                         i, out_w, wrap_w, tc_w, exp_out[i], exp_wrap[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_val = 8'd0; enable = 1'b0;
        step();
        checks++;
        if (out_w !== 4'd0) begin
            errors++; $display("FAIL wrap_down_load out=%0d exp 0", out_w);
        end
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        step();
        checks++;
        if (out_w !== 4'd9 || wrap_w !== 1'b1) begin
            errors++; $display("FAIL wrap_down_9 out=%0d wrap=%b exp 9/1", out_w, wrap_w);
        end
        step();
        checks++;
        if (out_w !== 4'd8 || wrap_w !== 1'b0) begin
            errors++; $display("FAIL wrap_down_8 out=%0d wrap=%b exp 8/0", out_w, wrap_w);
        end
        step();
        checks++;
        if (out_w !== 4'd7) begin
            errors++; $display("FAIL wrap_down_7 out=%0d exp 7", out_w);
        end
    endtask

    task automatic test_saturate();
        enable = 1'b0;
        rst = 1'b1; #1; rst = 1'b0;
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if (out_s !== i[3:0] || sat_s !== 1'b0) begin
                errors++; $display("FAIL sat_count[%0d] out=%0d sat=%b exp %0d/0", i, out_s, sat_s, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_s !== 4'd9 || sat_s !== 1'b1 || wrap_s !== 1'b0) begin
                errors++; $display("FAIL sat_hi[%0d] out=%0d sat=%b wrap=%b exp 9/1/0", i, out_s, sat_s, wrap_s);
            end
        end
        load = 1'b1; load_val = 8'd0;
        step();
        checks++;
        if (out_s !== 4'd0 || sat_s !== 1'b0) begin
            errors++; $display("FAIL sat_load0 out=%0d sat=%b exp 0/0", out_s, sat_s);
        end
        load = 1'b0; up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_s !== 4'd0 || sat_s !== 1'b1 || tc_s !== 1'b1) begin
                errors++; $display("FAIL sat_lo[%0d] out=%0d sat=%b tc=%b exp 0/1/1", i, out_s, sat_s, tc_s);
            end
        end
    endtask

    task automatic test_load();
        enable = 1'b1; up_down = 1'b1; load = 1'b1; load_val = 8'd13;
        step();
        checks++;
        if (out_w !== 4'd9 || wrap_w !== 1'b0 || sat_s !== 1'b0) begin
            errors++; $display("FAIL load_clamp out=%0d wrap=%b sat_s=%b exp 9/0/0", out_w, wrap_w, sat_s);
        end
        load_val = 8'd4;
        step();
        checks++;
        if (out_w !== 4'd4 || out_s !== 4'd4) begin
            errors++; $display("FAIL load_4 out_w=%0d out_s=%0d exp 4/4", out_w, out_s);
        end
        load = 1'b0; enable = 1'b0;
        step();
        step();
        checks++;
        if (out_w !== 4'd4 || wrap_w !== 1'b0) begin
            errors++; $display("FAIL load_hold out=%0d wrap=%b exp 4/0", out_w, wrap_w);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'd5; enable = 1'b0; up_down = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        checks++;
        if (out_w !== 4'd6) begin
            errors++; $display("FAIL areset_pre out=%0d exp 6", out_w);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_w !== 4'd0 || wrap_w !== 1'b0) begin
            errors++; $display("FAIL areset_now out=%0d wrap=%b exp 0/0", out_w, wrap_w);
        end
        rst = 1'b0;
        step();
        checks++;
        if (out_w !== 4'd1) begin
            errors++; $display("FAIL areset_resume1 out=%0d exp 1", out_w);
        end
        step();
        checks++;
        if (out_w !== 4'd2) begin
            errors++; $display("FAIL areset_resume2 out=%0d exp 2", out_w);
        end
    endtask

    task automatic test_default_params();
        load = 1'b1; load_val = 8'd254; enable = 1'b0; up_down = 1'b1;
        step();
        checks++;
        if (out_d !== 8'd254 || tc_d !== 1'b0) begin
            errors++; $display("FAIL def_load out=%0d tc=%b exp 254/0", out_d, tc_d);
        end
        load = 1'b0; enable = 1'b1;
        step();
        checks++;
        if (out_d !== 8'd255 || tc_d !== 1'b1 || wrap_d !== 1'b0) begin
            errors++; $display("FAIL def_255 out=%0d tc=%b wrap=%b exp 255/1/0", out_d, tc_d, wrap_d);
        end
        step();
        checks++;
        if (out_d !== 8'd0 || wrap_d !== 1'b1) begin
            errors++; $display("FAIL def_wrap out=%0d wrap=%b exp 0/1", out_d, wrap_d);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_d !== 8'd0 || wrap_d !== 1'b0 || sat_d !== 1'b0) begin
                errors++; $display("FAIL def_hold[%0d] out=%0d wrap=%b sat=%b exp 0/0/0", i, out_d, wrap_d, sat_d);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_async_reset();
        test_default_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
